// File: rtl/instr_cache_controller_if.sv
// Fetch/memory/AHB signal bundle for the instruction cache miss controller.
// The master modport is the controller side; slave is the fetch/memory/bus side.
interface instr_cache_controller_if;
    // Fetch address and cache memory status
    logic [31:0] A;
    logic        W1V;
    logic        W2V;
    logic        W1Hit;
    logic        W2Hit;
    logic        CurrLRU;
    logic [31:0] W1RD;
    logic [31:0] W2RD;
    // AHB read data phase
    logic        HReady;
    // Controller outputs
    logic [31:0] ANew;
    logic [1:0]  WordOffset;
    logic        W1WE;
    logic        W2WE;
    logic        ResetCounter;
    logic [31:0] HAddrF;
    logic        HRequestF;
    logic        IStall;
    logic [31:0] InstrF;

    modport master (
        input  A, W1V, W2V, W1Hit, W2Hit, CurrLRU, W1RD, W2RD, HReady,
        output ANew, WordOffset, W1WE, W2WE, ResetCounter, HAddrF, HRequestF,
               IStall, InstrF
    );

    modport slave (
        output A, W1V, W2V, W1Hit, W2Hit, CurrLRU, W1RD, W2RD, HReady,
        input  ANew, WordOffset, W1WE, W2WE, ResetCounter, HAddrF, HRequestF,
               IStall, InstrF
    );
endinterface

// File: rtl/instr_cache_controller.sv
// Miss-handling controller for the two-way instruction cache.
// Hits are served combinationally; a miss stalls fetch and refills one
// 4-word line over AHB into the victim way (invalid way first, else LRU).
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN starts the fill at
// the requested word and wraps; otherwise the fill always starts at word 0.
module instr_cache_controller #(
    parameter int unsigned tbits = 14,
    parameter int unsigned bsize = 4
) (
    input logic                      clk,
    input logic                      reset,
    instr_cache_controller_if.master bus
);
    localparam int unsigned CW = $clog2(bsize);
    localparam int unsigned IW = 28 - tbits;

    typedef enum logic {
        READY,
        FILL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   done_q, done_d;
    logic            victim_q, victim_d;   // 0: way 1, 1: way 2
    logic [tbits-1:0] tag_q, tag_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            miss;
    logic [31:0]     fill_addr;

    assign miss      = ~(bus.W1Hit | bus.W2Hit);
    assign fill_addr = {tag_q, idx_q, cnt_q, 2'b00};

    // State, fill counters, victim and line address registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= READY;
            cnt_q    <= '0;
            done_q   <= '0;
            victim_q <= 1'b0;
            tag_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            victim_q <= victim_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
        end
    end

    // Next state: latch the line and victim on a miss, step through the fill
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        victim_d = victim_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        case (state_q)
            READY: begin
                if (miss) begin
                    state_d = FILL;
                    tag_d   = bus.A[31 -: tbits];
                    idx_d   = bus.A[4 +: IW];
                    done_d  = '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                    cnt_d   = bus.A[2 +: CW];
`else
                    cnt_d   = '0;
`endif
                    if (!bus.W1V)      victim_d = 1'b0;
                    else if (!bus.W2V) victim_d = 1'b1;
                    else               victim_d = ~bus.CurrLRU;
                end
            end
            FILL: begin
                if (bus.HReady) begin
                    cnt_d  = cnt_q + 1'b1;
                    done_d = done_q + 1'b1;
                    if (done_q == CW'(bsize - 1)) state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    // Outputs: memory address/word select, write enables, AHB request, stall
    always_comb begin
        bus.ANew         = bus.A;
        bus.WordOffset   = bus.A[3:2];
        bus.InstrF       = bus.W1Hit ? bus.W1RD : bus.W2RD;
        bus.W1WE         = 1'b0;
        bus.W2WE         = 1'b0;
        bus.ResetCounter = 1'b0;
        bus.HAddrF       = '0;
        bus.HRequestF    = 1'b0;
        bus.IStall       = 1'b0;
        case (state_q)
            READY: begin
                bus.IStall       = miss;
                bus.ResetCounter = miss;
            end
            FILL: begin
                bus.ANew       = fill_addr;
                bus.WordOffset = cnt_q;
                bus.HAddrF     = fill_addr;
                bus.HRequestF  = 1'b1;
                bus.IStall     = 1'b1;
                bus.W1WE       = bus.HReady & ~victim_q;
                bus.W2WE       = bus.HReady & victim_q;
            end
            default: ;
        endcase
        // Reset is asynchronous, so the control strobes must drop with it
        // rather than waiting for the state register to settle.
        if (reset) begin
            bus.W1WE         = 1'b0;
            bus.W2WE         = 1'b0;
            bus.ResetCounter = 1'b0;
            bus.HRequestF    = 1'b0;
            bus.IStall       = 1'b0;
        end
    end
endmodule
